// File: rtl/membrane_state_controller.sv
// Membrane-potential state holder for one LIF neuron: integrate with shift leak and
// saturation, reset-on-spike, programmable refractory period and a threshold register.
module membrane_state_controller #(
  parameter int n_stage     = 2,
  parameter int REFRAC_BITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [n_stage+1:0]            syn_in,
  input  logic [1:0]                    leak_shift,
  input  logic [n_stage+1:0]            thr_in,
  input  logic                          load_thr,
  input  logic [REFRAC_BITS-1:0]        refrac_len,
  input  logic                          is_spike,
  output logic [n_stage+1:0]            u,
  output logic [n_stage+1:0]            minus_teta,
  output logic                          spike_out,
  output logic                          refractory
);

  localparam int W = n_stage + 2;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } state_t;

  state_t                 r_state;
  logic [W-1:0]           r_u;
  logic [W-1:0]           r_minusTeta;
  logic [REFRAC_BITS-1:0] r_cnt;
  logic                   r_spikeOut;
  logic                   r_refractory;

  logic [W-1:0]           w_leak;
  logic [W-1:0]           w_diff;
  logic [W:0]             w_sum;
  logic [W-1:0]           w_uNext;
  logic [W-1:0]           w_negThr;
  logic [W-1:0]           w_thrReset;

  // Leak never exceeds u, so the subtraction is safe; only the add needs a carry bit.
  always_comb begin
    w_leak     = (leak_shift == 2'd0) ? '0 : (r_u >> leak_shift);
    w_diff     = r_u - w_leak;
    w_sum      = {1'b0, w_diff} + {1'b0, syn_in};
    w_uNext    = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    w_negThr   = ~thr_in + {{(W-1){1'b0}}, 1'b1};
    w_thrReset = {1'b1, {(W-1){1'b0}}};
  end

  // The threshold is kept only in its negated form, which is what the comparator consumes;
  // the reset threshold 2^(W-1) is its own two's complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= INTEG;
      r_u          <= '0;
      r_minusTeta  <= w_thrReset;
      r_cnt        <= '0;
      r_spikeOut   <= 1'b0;
      r_refractory <= 1'b0;
    end else begin
      r_spikeOut <= 1'b0;
      if (load_thr) begin
        r_minusTeta <= w_negThr;
      end
      if (ena) begin
        case (r_state)
          INTEG: begin
            if (is_spike) begin
              r_u        <= '0;
              r_spikeOut <= 1'b1;
              if (refrac_len != '0) begin
                r_cnt        <= refrac_len;
                r_state      <= REFRAC;
                r_refractory <= 1'b1;
              end
            end else begin
              r_u <= w_uNext;
            end
          end
          REFRAC: begin
            r_u <= '0;
            if (r_cnt <= {{(REFRAC_BITS-1){1'b0}}, 1'b1}) begin
              r_cnt        <= '0;
              r_state      <= INTEG;
              r_refractory <= 1'b0;
            end else begin
              r_cnt <= r_cnt - {{(REFRAC_BITS-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            r_state      <= INTEG;
            r_cnt        <= '0;
            r_refractory <= 1'b0;
          end
        endcase
      end
    end
  end

  assign u          = r_u;
  assign minus_teta = r_minusTeta;
  assign spike_out  = r_spikeOut;
  assign refractory = r_refractory;

endmodule

// File: tb/tb_membrane_state_controller.sv
// Bench for membrane_state_controller: integer reference model checked every cycle,
// plus directed steps pinned with hand-computed literal values.
module tb_membrane_state_controller;

  localparam int W    = 4;
  localparam int UMAX = 15;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] synIn;
  logic [1:0] leakShift;
  logic [3:0] thrIn;
  logic       loadThr;
  logic [2:0] refracLen;
  logic       isSpike;
  logic [3:0] u;
  logic [3:0] minusTeta;
  logic       spikeOut;
  logic       refractory;

  int total = 0;
  int bad   = 0;

  // Reference state: potential, threshold, remaining blocked steps, pending pulse.
  int mU, mThr, mBlocked, mSpike;

  membrane_state_controller #(.n_stage(2), .REFRAC_BITS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .syn_in     (synIn),
    .leak_shift (leakShift),
    .thr_in     (thrIn),
    .load_thr   (loadThr),
    .refrac_len (refracLen),
    .is_spike   (isSpike),
    .u          (u),
    .minus_teta (minusTeta),
    .spike_out  (spikeOut),
    .refractory (refractory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int integrate(input int cur, input int shift, input int syn);
    int leak;
    int res;
    leak = (shift == 0) ? 0 : (cur >> shift);
    res  = cur - leak + syn;
    return (res > UMAX) ? UMAX : res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mU       <= 0;
      mThr     <= 8;
      mBlocked <= 0;
      mSpike   <= 0;
    end else begin
      mSpike <= 0;
      if (ena) begin
        if (mBlocked > 0) begin
          mBlocked <= mBlocked - 1;
          mU       <= 0;
        end else if (isSpike) begin
          mU       <= 0;
          mSpike   <= 1;
          mBlocked <= int'(refracLen);
        end else begin
          mU <= integrate(mU, int'(leakShift), int'(synIn));
        end
      end
      if (loadThr) mThr <= int'(thrIn);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkLit(input string name, input int dutVal, input int modelVal, input int lit);
    checkOutput(name, dutVal, lit);
    checkOutput({name, "_model"}, modelVal, lit);
  endtask

  // Every cycle, away from the rising edge, the DUT must agree with the model.
  always @(negedge clk) begin
    checkOutput("u", int'(u), mU);
    checkOutput("minus_teta", int'(minusTeta), (16 - mThr) % 16);
    checkOutput("spike_out", int'(spikeOut), mSpike);
    checkOutput("refractory", int'(refractory), (mBlocked > 0) ? 1 : 0);
  end

  task automatic applyStimulus(input logic e, input int syn, input int ls, input logic spk);
    ena       = e;
    synIn     = 4'(syn);
    leakShift = 2'(ls);
    isSpike   = spk;
    @(negedge clk);
    loadThr = 1'b0;
  endtask

  task automatic checkAll(input string tag, input int eu, input int emt, input int esp,
                          input int eref);
    checkLit({tag, "_u"}, int'(u), mU, eu);
    checkLit({tag, "_mt"}, int'(minusTeta), (16 - mThr) % 16, emt);
    checkLit({tag, "_spk"}, int'(spikeOut), mSpike, esp);
    checkLit({tag, "_ref"}, int'(refractory), (mBlocked > 0) ? 1 : 0, eref);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; synIn = '0; leakShift = '0; thrIn = '0;
    loadThr = 1'b0; refracLen = '0; isSpike = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkAll("reset", 0, 8, 0, 0);

    applyStimulus(1, 3, 0, 0); checkAll("int1", 3, 8, 0, 0);
    applyStimulus(1, 3, 0, 0); checkAll("int2", 6, 8, 0, 0);
    applyStimulus(1, 3, 0, 0); checkAll("int3", 9, 8, 0, 0);
    applyStimulus(1, 15, 0, 0); checkAll("sat1", 15, 8, 0, 0);
    applyStimulus(1, 15, 0, 0); checkAll("sat2", 15, 8, 0, 0);
    applyStimulus(0, 7, 1, 0);
    applyStimulus(0, 7, 1, 0); checkAll("idle", 15, 8, 0, 0);

    applyStimulus(1, 0, 2, 0); checkAll("leak0", 12, 8, 0, 0);
    applyStimulus(1, 0, 2, 0); checkAll("leak1", 9, 8, 0, 0);
    applyStimulus(1, 0, 2, 0); checkAll("leak2", 7, 8, 0, 0);
    applyStimulus(1, 1, 2, 0); checkAll("leak3", 7, 8, 0, 0);
    applyStimulus(1, 2, 0, 0); checkAll("pre", 9, 8, 0, 0);

    refracLen = 3'd2;
    applyStimulus(1, 5, 0, 1); checkAll("spk", 0, 8, 1, 1);
    refracLen = 3'd5;
    applyStimulus(1, 5, 0, 1); checkAll("ref1", 0, 8, 0, 1);
    applyStimulus(0, 5, 0, 0); checkAll("gap", 0, 8, 0, 1);
    applyStimulus(1, 5, 0, 1); checkAll("ref2", 0, 8, 0, 0);
    applyStimulus(1, 5, 0, 0); checkAll("post", 5, 8, 0, 0);

    refracLen = 3'd0;
    applyStimulus(1, 5, 0, 1); checkAll("spk0", 0, 8, 1, 0);
    applyStimulus(1, 5, 0, 0); checkAll("post0", 5, 8, 0, 0);

    thrIn = 4'd5; loadThr = 1'b1;
    applyStimulus(0, 0, 0, 0); checkAll("thr5", 5, 11, 0, 0);
    thrIn = 4'd3; loadThr = 1'b1;
    applyStimulus(1, 0, 0, 1); checkAll("thrSame", 0, 13, 1, 0);
    thrIn = 4'd0; loadThr = 1'b1;
    applyStimulus(0, 0, 0, 0); checkAll("thr0", 0, 0, 0, 0);
    thrIn = 4'd5; loadThr = 1'b1;
    applyStimulus(0, 0, 0, 0); checkAll("thr5b", 0, 11, 0, 0);

    refracLen = 3'd7;
    applyStimulus(1, 0, 0, 1); checkAll("spk7", 0, 11, 1, 1);
    applyStimulus(1, 4, 0, 0);
    applyStimulus(1, 4, 0, 0); checkAll("mid7", 0, 11, 0, 1);
    #2 rst_n = 1'b0;
    #1 checkAll("asyncRst", 0, 8, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 4, 0, 0); checkAll("afterRst", 4, 8, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
